// File: rtl/multi_byte_add_seq_pkg.sv
// Shared constants and FSM state type for the byte-serial adder.
// Imported by multi_byte_add_seq and byte_adder8.
package multi_byte_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_byte_add_seq_byte_adder8.sv
// byte_adder8: combinational 8-bit adder with carry in and carry out.
// Ports: op1/op2 [7:0] operands, cin carry in, sum [8:0] = {carry, byte}.
module byte_adder8
    import multi_byte_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] op1,
    input  logic [BYTE_W-1:0] op2,
    input  logic              cin,
    output logic [BYTE_W:0]   sum
);

    always_comb begin
        sum = {1'b0, op1} + {1'b0, op2} + {{BYTE_W{1'b0}}, cin};
    end

endmodule

// File: rtl/multi_byte_add_seq.sv
// Byte-serial adder: adds two NBYTES-byte operands one byte per cycle.
// Ports: clk, rst_n (async, active-low), in_valid/in_ready operand
// handshake, op1/op2 [8*NBYTES-1:0], cin, out_valid/out_ready result
// handshake, sum [8*NBYTES:0] with final carry in the MSB.
// Optional: define MULTI_BYTE_ADD_SEQ_OVF_EN to add the 1-bit ovf output
// (signed overflow of the NBYTES-byte add, valid with out_valid).
module multi_byte_add_seq
    import multi_byte_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BYTE_W*NBYTES-1:0]   op1,
    input  logic [BYTE_W*NBYTES-1:0]   op2,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BYTE_W*NBYTES:0]     sum
`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int OP_W  = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_fin;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [OP_W:0]      r_sum;
    logic [BYTE_W-1:0]  w_a_byte;
    logic [BYTE_W-1:0]  w_b_byte;
    logic [BYTE_W:0]    w_add;
    logic               w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_a_byte = r_a[BYTE_W*r_idx +: BYTE_W];
    assign w_b_byte = r_b[BYTE_W*r_idx +: BYTE_W];

    byte_adder8 u_add (
        .op1 (w_a_byte),
        .op2 (w_b_byte),
        .cin (r_carry),
        .sum (w_add)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_fin marks the extra RUN cycle that commits the final carry,
    // giving NBYTES+1 cycles from acceptance to out_valid.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (r_fin) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_fin   <= 1'b0;
            r_sum   <= '0;
        end else if (w_accept) begin
            r_a     <= op1;
            r_b     <= op2;
            r_carry <= cin;
            r_idx   <= '0;
            r_fin   <= 1'b0;
        end else if (r_state == RUN) begin
            if (r_fin) begin
                r_sum[OP_W] <= r_carry;
                r_fin       <= 1'b0;
            end else begin
                r_sum[BYTE_W*r_idx +: BYTE_W] <= w_add[BYTE_W-1:0];
                r_carry <= w_add[BYTE_W];
                if (r_idx == LAST) begin
                    r_idx <= '0;
                    r_fin <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign sum = r_sum;

`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Same-sign operands producing a different-sign MSB is exactly
    // carry-into-MSB xor carry-out-of-MSB.
    assign w_ovf = (r_a[OP_W-1] == r_b[OP_W-1]) &&
                   (w_add[BYTE_W-1] != r_a[OP_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && !r_fin && r_idx == LAST) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Self-checking bench for multi_byte_add_seq (NBYTES=4).
// Spec-level model plus directed vectors with literal expectations.
module tb_multi_byte_add_seq;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     sum;
`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
    logic           ovf;
`endif

    int total = 0;
    int bad   = 0;

    multi_byte_add_seq #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 busy counting edges, 2 result available.
    int         m_phase = 0;
    int         m_cnt   = 0;
    logic [W:0] m_sum   = '0;
    logic       m_ovf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_sum   = {1'b0, op1} + {1'b0, op2} + {{W{1'b0}}, cin};
                    m_ovf   = (op1[W-1] == op2[W-1]) && (m_sum[W-1] != op1[W-1]);
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == N + 1) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", {63'd0, in_ready}, 64'd1);
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_sum", {31'd0, sum}, 64'd0);
        end else begin
            check("in_ready", {63'd0, in_ready}, {63'd0, m_phase == 0});
            check("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
            if (m_phase == 2) begin
                check("sum", {31'd0, sum}, {31'd0, m_sum});
`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
                check("ovf", {63'd0, ovf}, {63'd0, m_ovf});
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W:0] lit,
                          input logic lit_ovf, input int hold,
                          input bit poke);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; op1 = a; op2 = b; cin = c; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (1) begin
            if (poke) begin
                in_valid = lat[0] ? 1'b0 : 1'b1;
                op1 = W'($urandom);
                op2 = W'($urandom);
                cin = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (lat > 20) begin
                check("timeout", 64'(lat), 64'(N + 1));
                break;
            end
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), 64'd5);
        check("sum_lit", {31'd0, sum}, {31'd0, lit});
`ifdef MULTI_BYTE_ADD_SEQ_OVF_EN
        check("ovf_lit", {63'd0, ovf}, {63'd0, lit_ovf});
`else
        if (lit_ovf === 1'bx) check("ovf_unused", 64'd0, 64'd1);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_sum", {31'd0, sum}, {31'd0, lit});
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", {63'd0, out_valid}, 64'd0);
        check("post_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, 1'b0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, 1'b0, 0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1, 0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b1, 0, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 33'h0_ACF1_3569, 1'b0, 3, 0);

        // Abort mid-operation at byte index 2.
        @(posedge clk); #1;
        in_valid = 1'b1; op1 = 32'hFFFF_0000; op2 = 32'h0001_0000; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", {63'd0, out_valid}, 64'd0);
        end
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002, 1'b0, 0, 0);

        // Operands changing during RUN must not affect the result.
        run_op(32'h0001_0203, 32'h0F0E_0D0C, 1'b0, 33'h0_0F0F_0F0F, 1'b0, 1, 1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_byte_add_seq.md
MULTI_BYTE_ADD_SEQ -- requirements
Module: multi_byte_add_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal values 2 to 16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream operands are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port op1, input, 8*NBYTES bits: first operand.
REQ-007 The block SHALL have port op2, input, 8*NBYTES bits: second operand.
REQ-008 The block SHALL have port cin, input, 1 bit: carry into the LSB.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port sum, output, 8*NBYTES+1 bits: the result, with the final carry in the MSB.

Function
REQ-012 The block SHALL accept operands on a clk edge where in_valid && in_ready, and SHALL register op1, op2 and cin at that edge.
REQ-013 The block SHALL use an FSM with states IDLE, RUN and DONE.
REQ-014 The block SHALL assert in_ready only in IDLE; a handshake in IDLE SHALL move the FSM to RUN with byte index 0.
REQ-015 In RUN, the block SHALL add one byte per cycle, LSB byte first, through an 8-bit adder.
REQ-016 The carry-in of byte 0 SHALL be the registered cin; the carry-in of byte k SHALL be the registered carry-out of byte k-1.
REQ-017 Each byte result SHALL be written into the sum register at byte lane k, and the byte index SHALL increment.
REQ-018 After byte NBYTES-1, the FSM SHALL go to DONE, and sum[8*NBYTES] SHALL hold the final carry.
REQ-019 Latency SHALL be exactly NBYTES+1 cycles from the accepting edge to the first cycle with out_valid=1.
REQ-020 In DONE, out_valid SHALL be 1, and sum SHALL be held stable until out_ready=1.
REQ-021 On DONE with out_ready=1, the FSM SHALL return to IDLE on that edge.
REQ-022 There SHALL be no back-to-back overlap: the next acceptance occurs no earlier than the cycle after the output handshake.
REQ-023 Arithmetic SHALL be unsigned modulo 2^(8*NBYTES+1); all-ones + all-ones + cin=1 SHALL give sum = 2^(8*NBYTES+1)-1.
REQ-024 in_valid, op1 and op2 SHALL be ignored outside IDLE.
REQ-025 The block SHALL be throughput-limited to one operation per NBYTES+2 cycles minimum.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in IDLE, with in_ready=1, out_valid=0, sum=0, byte index=0 and carry register=0.
REQ-027 A reset asserted mid-RUN or in DONE SHALL abort the operation without producing output; the first acceptance SHALL be possible on the first edge after rst_n rises.

Configuration
REQ-028 When macro MULTI_BYTE_ADD_SEQ_OVF_EN is defined, the block SHALL add an output port ovf, 1 bit: two's-complement signed overflow of the NBYTES-byte add (carry into MSB xor carry out of MSB), valid with out_valid and reset to 0.
REQ-029 When MULTI_BYTE_ADD_SEQ_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package multi_byte_add_seq_pkg SHALL hold the BYTE_W=8 constant and the FSM state enum type (IDLE, RUN, DONE).
REQ-031 The per-byte add SHALL be a sub-module named byte_adder8: combinational, with 8-bit op1 and op2, a cin input, and a 9-bit sum output.
REQ-032 The byte index counter SHALL be $clog2(NBYTES) bits wide.

Verification
REQ-033 The bench SHALL cover: NBYTES=4, op1=0x0000_00FF, op2=0x0000_0001, cin=0 -> sum=0x0_0000_0100, out_valid exactly 5 cycles after acceptance.
REQ-034 The bench SHALL cover: op1=op2=0xFFFF_FFFF, cin=1 -> sum=0x1_FFFF_FFFF, and ovf=0 when MULTI_BYTE_ADD_SEQ_OVF_EN is defined.
REQ-035 The bench SHALL cover: op1=0x7FFF_FFFF, op2=0x0000_0001, cin=0 -> sum=0x0_8000_0000, and ovf=1 when MULTI_BYTE_ADD_SEQ_OVF_EN is defined.
REQ-036 The bench SHALL cover: out_ready held 0 for 3 cycles in DONE -> sum stable, out_valid=1, in_ready=0 throughout; release -> IDLE on the next edge.
REQ-037 The bench SHALL cover: rst_n pulsed low at RUN byte 2 -> out_valid never asserts, and a new op 0x1+0x1 accepted after reset -> sum=0x2.
REQ-038 The bench SHALL cover: in_valid toggled with changing op1 during RUN -> the result reflects only the operands captured at acceptance.
